// File: rtl/dsky_relay_decoder.sv
// rtl/dsky_relay_decoder.sv - channel-10 relay row decoder with timed pickup
// Strobes are detected from registered WCH10_; the matching RLYB/RYWD sample commits after PICKUP_CYCLES.
module dsky_relay_decoder #(
  parameter int GATE_DELAY    = 20,
  parameter int PICKUP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] RLYB,
  input  logic [3:0]  RYWD,
  input  logic        WCH10_,
  input  logic        CCH10,
  input  logic [3:0]  RD_ROW,
  output logic [10:0] RD_DATA,
  output logic        BUSY,
  output logic        ROWUPD,
  output logic [3:0]  UPD_ROW,
  output logic [3:0]  BADCNT
);

  if (PICKUP_CYCLES < 1 || PICKUP_CYCLES > 15 || GATE_DELAY < 0) begin : g_bad_param
    $error("dsky_relay_decoder: PICKUP_CYCLES must be 1..15");
  end

  typedef enum logic {IDLE, PICKUP} state_t;

  state_t      state;
  logic        wch_low_q;
  logic        wch_low_p;
  logic [10:0] rlyb_q;
  logic [3:0]  rywd_q;
  logic [10:0] pend_bits;
  logic [3:0]  pend_row;
  logic [3:0]  cnt;
  logic [10:0] rows [12];
  logic        strobe;

  function automatic logic row_ok(input logic [3:0] r);
    return (r >= 4'd1) && (r <= 4'd12);
  endfunction

  // History holds "WCH10_ seen low"; resetting it to 1 hides a strobe already low at release.
  assign strobe = wch_low_q & ~wch_low_p;
  assign BUSY   = (state == PICKUP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wch_low_q <= 1'b1;
      wch_low_p <= 1'b1;
      rlyb_q    <= '0;
      rywd_q    <= '0;
      pend_bits <= '0;
      pend_row  <= '0;
      cnt       <= '0;
      RD_DATA   <= '0;
      ROWUPD    <= 1'b0;
      UPD_ROW   <= '0;
      BADCNT    <= '0;
      for (int i = 0; i < 12; i++) rows[i] <= '0;
    end else begin
      wch_low_q <= ~WCH10_;
      wch_low_p <= wch_low_q;
      rlyb_q    <= RLYB;
      rywd_q    <= RYWD;
      ROWUPD    <= 1'b0;
      RD_DATA   <= row_ok(RD_ROW) ? rows[RD_ROW - 4'd1] : '0;
      if (CCH10) begin
        state  <= IDLE;
        cnt    <= '0;
        BADCNT <= '0;
        for (int i = 0; i < 12; i++) rows[i] <= '0;
      end else begin
        if (state == PICKUP) begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rows[pend_row - 4'd1] <= pend_bits;
            ROWUPD                <= 1'b1;
            UPD_ROW               <= pend_row;
            state                 <= IDLE;
          end
        end
        // A new valid strobe overrides the commit's return to IDLE and reloads the pickup.
        if (strobe) begin
          if (row_ok(rywd_q)) begin
            pend_bits <= rlyb_q;
            pend_row  <= rywd_q;
            cnt       <= 4'(PICKUP_CYCLES);
            state     <= PICKUP;
          end else if (BADCNT != 4'hF) begin
            BADCNT <= BADCNT + 4'd1;
          end
        end
      end
    end
  end

endmodule
